// File: rtl/drbg_seq_header_decoder.sv
// rtl/drbg_seq_header_decoder.sv - frame header parser recovering the sender's DRBG sequence number and V flag
// Optional HDR_ERR_COUNT_EN adds a saturating header_error counter on err_count.
module drbg_seq_header_decoder #(
  parameter logic [7:0] MAGIC0         = 8'hA5,
  parameter logic [7:0] MAGIC1         = 8'h5A,
  parameter int         TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_start,
  input  logic        pixel_valid,
  input  logic [7:0]  pixel_data,
  output logic [31:0] sequence_external,
  output logic        sequence_external_valid,
  output logic        V,
  output logic        header_error,
  output logic        busy
`ifdef HDR_ERR_COUNT_EN
  ,
  output logic [15:0] err_count
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_M0    = 3'd1;
  localparam logic [2:0] S_M1    = 3'd2;
  localparam logic [2:0] S_SEQ   = 3'd3;
  localparam logic [2:0] S_FLAGS = 3'd4;
  localparam logic [2:0] S_CSUM  = 3'd5;

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [2:0]    state;
  logic [2:0]    cur_state;
  logic [1:0]    seq_cnt;
  logic [31:0]   seq_shadow;
  logic [7:0]    flags_shadow;
  logic [TW-1:0] idle_cnt;
  logic [7:0]    csum_calc;

  // frame_start restarts at M0 from any state, so a same-cycle byte is judged as MAGIC0
  assign cur_state = frame_start ? S_M0 : state;
  assign csum_calc = seq_shadow[31:24] ^ seq_shadow[23:16] ^ seq_shadow[15:8]
                   ^ seq_shadow[7:0] ^ flags_shadow;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state                   <= S_IDLE;
      seq_cnt                 <= 2'd0;
      seq_shadow              <= 32'd0;
      flags_shadow            <= 8'd0;
      idle_cnt                <= '0;
      sequence_external       <= 32'd0;
      V                       <= 1'b0;
      sequence_external_valid <= 1'b0;
      header_error            <= 1'b0;
    end else begin
      sequence_external_valid <= 1'b0;
      header_error            <= 1'b0;
      if (frame_start) begin
        state    <= S_M0;
        idle_cnt <= '0;
        seq_cnt  <= 2'd0;
      end
      if (cur_state != S_IDLE) begin
        if (pixel_valid) begin
          idle_cnt <= '0;
          case (cur_state)
            S_M0: begin
              if (pixel_data == MAGIC0) begin
                state <= S_M1;
              end else begin
                state        <= S_IDLE;
                header_error <= 1'b1;
              end
            end
            S_M1: begin
              if (pixel_data == MAGIC1) begin
                state   <= S_SEQ;
                seq_cnt <= 2'd0;
              end else begin
                state        <= S_IDLE;
                header_error <= 1'b1;
              end
            end
            S_SEQ: begin
              seq_shadow <= {seq_shadow[23:0], pixel_data};
              seq_cnt    <= seq_cnt + 2'd1;
              if (seq_cnt == 2'd3) begin
                state <= S_FLAGS;
              end
            end
            S_FLAGS: begin
              flags_shadow <= pixel_data;
              state        <= S_CSUM;
            end
            S_CSUM: begin
              state <= S_IDLE;
              if (pixel_data == csum_calc) begin
                sequence_external       <= seq_shadow;
                V                       <= flags_shadow[0];
                sequence_external_valid <= 1'b1;
              end else begin
                header_error <= 1'b1;
              end
            end
            default: state <= S_IDLE;
          endcase
        end else if (!frame_start) begin
          // idle_cnt holds the number of starved busy cycles already seen
          if (idle_cnt == IDLE_LAST) begin
            header_error <= 1'b1;
            state        <= S_IDLE;
            idle_cnt     <= '0;
          end else begin
            idle_cnt <= idle_cnt + TW'(1);
          end
        end
      end
    end
  end

`ifdef HDR_ERR_COUNT_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_count <= 16'd0;
    end else if (header_error && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_drbg_seq_header_decoder.sv
// tb/tb_drbg_seq_header_decoder.sv - directed scoreboard bench for drbg_seq_header_decoder
// Optional HDR_ERR_COUNT_EN enables the err_count checks.
module tb_drbg_seq_header_decoder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        pixel_valid = 1'b0;
  logic [7:0]  pixel_data = 8'd0;
  logic [31:0] sequence_external;
  logic        sequence_external_valid;
  logic        V;
  logic        header_error;
  logic        busy;
`ifdef HDR_ERR_COUNT_EN
  logic [15:0] err_count;
`endif

  drbg_seq_header_decoder dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .frame_start             (frame_start),
    .pixel_valid             (pixel_valid),
    .pixel_data              (pixel_data),
    .sequence_external       (sequence_external),
    .sequence_external_valid (sequence_external_valid),
    .V                       (V),
    .header_error            (header_error),
    .busy                    (busy)
`ifdef HDR_ERR_COUNT_EN
    ,
    .err_count               (err_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        kind;
    logic [31:0] seq;
    logic        v;
    int          due;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  logic mon_en = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && (sequence_external_valid || header_error)) begin
      check("pulse_overlap", {31'd0, sequence_external_valid & header_error}, 32'd0);
      check("pulse_expected", {31'd0, q.size() != 0}, 32'd1);
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        check("pulse_kind", {31'd0, sequence_external_valid}, {31'd0, e.kind});
        if (e.kind) begin
          check("pulse_seq", sequence_external, e.seq);
          check("pulse_v", {31'd0, V}, {31'd0, e.v});
        end
        if (e.due != 0) check("pulse_cycle", cyc, e.due);
      end
    end
  end

  task automatic idle(input int n);
    frame_start = 1'b0;
    pixel_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input logic fs);
    frame_start = fs;
    pixel_valid = 1'b1;
    pixel_data  = b;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    pixel_valid = 1'b0;
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    pixel_valid = 1'b0;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
  endtask

  task automatic expect_ev(input logic kind, input logic [31:0] seq, input logic v, input int due);
    exp_t e;
    e.kind = kind;
    e.seq  = seq;
    e.v    = v;
    e.due  = due;
    q.push_back(e);
  endtask

  task automatic send_header(input logic [31:0] seq, input logic [7:0] flags,
                             input logic [7:0] csum, input int gap, input logic ok);
    logic [7:0] hb [8];
    hb[0] = 8'hA5; hb[1] = 8'h5A;
    hb[2] = seq[31:24]; hb[3] = seq[23:16]; hb[4] = seq[15:8]; hb[5] = seq[7:0];
    hb[6] = flags; hb[7] = csum;
    pulse_fs();
    for (int i = 0; i < 8; i++) begin
      if (i == 7) expect_ev(ok, seq, flags[0], cyc + 1);
      send(hb[i], 1'b0);
      if (gap > 0 && i < 7) idle(gap);
    end
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    frame_start = 1'b0;
    pixel_valid = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #1;
    do_reset();
    idle(2);
    check("reset_seq", sequence_external, 32'd0);
    check("reset_v", {31'd0, V}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_valid", {31'd0, sequence_external_valid}, 32'd0);
    check("reset_err", {31'd0, header_error}, 32'd0);

    send_header(32'h0000001A, 8'h01, 8'h1B, 0, 1'b1);
    idle(2);
    check("valid_seq", sequence_external, 32'h0000001A);
    check("valid_v", {31'd0, V}, 32'd1);
    check("valid_busy", {31'd0, busy}, 32'd0);

    send_header(32'h00000024, 8'h00, 8'h25, 0, 1'b0);
    idle(2);
    check("badcsum_seq_hold", sequence_external, 32'h0000001A);
    check("badcsum_v_hold", {31'd0, V}, 32'd1);

    send_header(32'h12345678, 8'h00, 8'h08, 10, 1'b1);
    idle(2);
    check("gapped_seq", sequence_external, 32'h12345678);
    check("gapped_v", {31'd0, V}, 32'd0);

    pulse_fs();
    send(8'hA5, 1'b0);
    send(8'h5A, 1'b0);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    idle(63);
    check("timeout_busy_63", {31'd0, busy}, 32'd1);
    expect_ev(1'b0, 32'd0, 1'b0, cyc + 1);
    idle(1);
    check("timeout_busy_64", {31'd0, busy}, 32'd0);
    idle(2);

    pulse_fs();
    send(8'hA5, 1'b0);
    send(8'h5A, 1'b0);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'hA5, 1'b1);
    send(8'h5A, 1'b0);
    for (int i = 0; i < 4; i++) send(8'hFF, 1'b0);
    send(8'h00, 1'b0);
    expect_ev(1'b1, 32'hFFFFFFFF, 1'b0, cyc + 1);
    send(8'h00, 1'b0);
    idle(2);
    check("restart_seq", sequence_external, 32'hFFFFFFFF);

    expect_ev(1'b0, 32'd0, 1'b0, cyc + 1);
    send(8'hA4, 1'b1);
    idle(1);
    check("badmagic_busy", {31'd0, busy}, 32'd0);

    send(8'hA5, 1'b0);
    send(8'h5A, 1'b0);
    check("idle_ignore_busy", {31'd0, busy}, 32'd0);
    idle(2);

    pulse_fs();
    send(8'hA5, 1'b0);
    send(8'h5A, 1'b0);
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'h04, 1'b0);
    do_reset();
    check("midreset_seq", sequence_external, 32'd0);
    check("midreset_v", {31'd0, V}, 32'd0);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    idle(2);
    send_header(32'h0A0B0C0D, 8'h01, 8'h01, 0, 1'b1);
    idle(2);
    check("post_reset_seq", sequence_external, 32'h0A0B0C0D);
    check("post_reset_v", {31'd0, V}, 32'd1);

`ifdef HDR_ERR_COUNT_EN
    do_reset();
    check("errcnt_reset", {16'd0, err_count}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      expect_ev(1'b0, 32'd0, 1'b0, cyc + 1);
      send(8'h00, 1'b1);
      idle(1);
    end
    idle(2);
    check("errcnt_three", {16'd0, err_count}, 32'd3);
    mon_en      = 1'b0;
    frame_start = 1'b1;
    pixel_valid = 1'b1;
    pixel_data  = 8'h00;
    repeat (65537) @(posedge clk);
    #1;
    idle(3);
    mon_en = 1'b1;
    check("errcnt_saturate", {16'd0, err_count}, 32'h0000FFFF);
`endif

    idle(4);
    check("queue_drained", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
